// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: address/counter widths, reset PC, opcodes,
// instruction field positions and the IF/ID payload type.
package inst_fetch_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned INST_W = 32;

    // Word 0 is left empty; execution starts at word 1.
    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1);

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned OFF_MSB  = 25;
    localparam int unsigned OFF_LSB  = 10;
    localparam int unsigned JTGT_MSB = 25;
    localparam int unsigned JTGT_LSB = 0;

    localparam logic [5:0] OP_JUMP = 6'h12;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_BNE  = 6'h10;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_plus1;
    } ifid_t;

    function automatic logic is_jump(input logic [INST_W-1:0] inst);
        return inst[OPC_MSB:OPC_LSB] == OP_JUMP;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM port, execute redirect and IF/ID handshake to decode.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              id_ready;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_plus1;
    logic [CNT_W-1:0]  fetch_cnt;

    modport master (
        output rom_addr, id_valid, id_inst, id_pc, id_pc_plus1, fetch_cnt,
        input  rom_inst, redirect_valid, redirect_target, id_ready
    );

    modport slave (
        input  rom_addr, id_valid, id_inst, id_pc, id_pc_plus1, fetch_cnt,
        output rom_inst, redirect_valid, redirect_target, id_ready
    );

endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, next-PC mux with jump pre-decode, IF/ID register
// with valid/ready to decode, and a saturating count of loaded instructions.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    inst_fetch_if.master bus
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    ifid_t             ifid_q, ifid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_c;
    logic [ADDR_W-1:0] pc_inc_c;

    assign load_c   = !valid_q || bus.id_ready;
    assign pc_inc_c = pc_q + ADDR_W'(1);

    // Redirect flushes IF/ID and wins over any load or fetched jump.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        ifid_d  = ifid_q;
        cnt_d   = cnt_q;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_target;
            valid_d = 1'b0;
        end else if (load_c) begin
            ifid_d.inst     = bus.rom_inst;
            ifid_d.pc       = pc_q;
            ifid_d.pc_plus1 = pc_inc_c;
            valid_d         = 1'b1;
            cnt_d           = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            pc_d            = is_jump(bus.rom_inst) ? bus.rom_inst[JTGT_LSB +: ADDR_W]
                                                    : pc_inc_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ifid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ifid_q  <= ifid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.id_valid    = valid_q;
    assign bus.id_inst     = ifid_q.inst;
    assign bus.id_pc       = ifid_q.pc;
    assign bus.id_pc_plus1 = ifid_q.pc_plus1;
    assign bus.fetch_cnt   = cnt_q;

endmodule
